// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - ID-stage hazard unit: forwarding, load-use, MDU scoreboard, SMC flush
module pipe_hazard_ctrl #(
  parameter int RB         = 5,
  parameter int FWD_STAGES = 2,
  parameter int MDU_LAT    = 4,
  parameter int SMC_DRAIN  = 2,
  parameter int AW         = 32,
  localparam int FW        = $clog2(FWD_STAGES + 1)
) (
  input  logic                     clk_i,
  input  logic                     resetn_i,
  input  logic                     id_valid_i,
  input  logic [RB-1:0]            id_rs_i,
  input  logic [RB-1:0]            id_rt_i,
  input  logic                     id_use_rs_i,
  input  logic                     id_use_rt_i,
  input  logic                     id_wreg_i,
  input  logic [RB-1:0]            id_des_i,
  input  logic                     id_is_mdu_i,
  input  logic [FWD_STAGES-1:0]    st_wreg_i,
  input  logic [FWD_STAGES-1:0]    st_m2reg_i,
  input  logic [FWD_STAGES*RB-1:0] st_des_i,
  input  logic                     ex_wmem_i,
  input  logic [AW-1:0]            ex_addr_i,
  input  logic [AW-1:0]            id_pc_i,
  input  logic [AW-1:0]            if_pc_i,
  output logic [FW-1:0]            fwda_o,
  output logic [FW-1:0]            fwdb_o,
  output logic                     stall_o,
  output logic                     mdu_busy_o,
  output logic                     mdu_done_o,
  output logic [RB-1:0]            mdu_des_o,
  output logic                     smc_flush_o,
  output logic                     smc_flush2_o
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DRAIN = 1'b1
  } smc_state_e;

  // MDU scoreboard state
  logic          pend_q, pend_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [RB-1:0] mdu_des_q, mdu_des_d;

  // SMC drain FSM state
  smc_state_e    state_q, state_d;
  logic [2:0]    dcnt_q, dcnt_d;

  // Combinational hazard terms
  logic [FW-1:0] fwda_c, fwdb_c;
  logic          load_use;
  logic          mdu_stall;
  logic          smc_hit;
  logic          drain;
  logic          stall_c;
  logic          issue;
  logic          mdu_done_c;
  logic          flush2_c;

  // A source operand hazard needs the read enabled and a nonzero index;
  // $0 is hardwired so it can never depend on an in-flight write.
  function automatic logic src_match(input logic use_f, input logic [RB-1:0] idx,
                                     input logic [RB-1:0] des);
    return use_f && (idx != '0) && (idx == des);
  endfunction

  // Forwarding select: nearest stage with a matching write wins
  always_comb begin
    logic found_a;
    logic found_b;
    fwda_c  = '0;
    fwdb_c  = '0;
    found_a = 1'b0;
    found_b = 1'b0;
    for (int k = 0; k < FWD_STAGES; k++) begin
      if (!found_a && st_wreg_i[k] && src_match(id_use_rs_i, id_rs_i, st_des_i[k*RB +: RB])) begin
        fwda_c  = FW'(k + 1);
        found_a = 1'b1;
      end
      if (!found_b && st_wreg_i[k] && src_match(id_use_rt_i, id_rt_i, st_des_i[k*RB +: RB])) begin
        fwdb_c  = FW'(k + 1);
        found_b = 1'b1;
      end
    end
  end

  // Stall sources: load in EX, MDU dependencies, SMC hit and drain window
  always_comb begin
    load_use = st_m2reg_i[0] && st_wreg_i[0] &&
               (src_match(id_use_rs_i, id_rs_i, st_des_i[RB-1:0]) ||
                src_match(id_use_rt_i, id_rt_i, st_des_i[RB-1:0]));
    // WAW ignores $0 writes: they are discarded and cannot race the MDU result.
    mdu_stall = pend_q &&
                (src_match(id_use_rs_i, id_rs_i, mdu_des_q) ||
                 src_match(id_use_rt_i, id_rt_i, mdu_des_q) ||
                 (id_wreg_i && (id_des_i != '0) && (id_des_i == mdu_des_q)) ||
                 id_is_mdu_i);
    smc_hit    = (state_q == S_IDLE) && ex_wmem_i && (ex_addr_i == id_pc_i);
    drain      = (state_q == S_DRAIN);
    stall_c    = load_use || mdu_stall || smc_hit || drain;
    issue      = id_valid_i && id_is_mdu_i && !stall_c;
    mdu_done_c = pend_q && (cnt_q == 4'd0);
    flush2_c   = ex_wmem_i && (ex_addr_i == if_pc_i);
  end

  // MDU scoreboard next state; the counter runs regardless of pipeline stalls
  always_comb begin
    pend_d    = pend_q;
    cnt_d     = cnt_q;
    mdu_des_d = mdu_des_q;
    if (pend_q) begin
      if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        pend_d = 1'b0;
      end
    end
    if (issue) begin
      pend_d    = 1'b1;
      mdu_des_d = id_des_i;
      cnt_d     = 4'(MDU_LAT - 1);
    end
  end

  // SMC FSM next state; store hits while draining are not re-armed
  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      S_IDLE: begin
        if (smc_hit) begin
          dcnt_d  = 3'(SMC_DRAIN - 1);
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (dcnt_q == 3'd0) begin
          state_d = S_IDLE;
        end else begin
          dcnt_d = dcnt_q - 3'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      pend_q    <= 1'b0;
      cnt_q     <= 4'd0;
      mdu_des_q <= '0;
      state_q   <= S_IDLE;
      dcnt_q    <= 3'd0;
    end else begin
      pend_q    <= pend_d;
      cnt_q     <= cnt_d;
      mdu_des_q <= mdu_des_d;
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
    end
  end

  // Outputs are held quiet for as long as reset is asserted
  always_comb begin
    fwda_o       = '0;
    fwdb_o       = '0;
    stall_o      = 1'b0;
    mdu_busy_o   = 1'b0;
    mdu_done_o   = 1'b0;
    mdu_des_o    = '0;
    smc_flush_o  = 1'b0;
    smc_flush2_o = 1'b0;
    if (resetn_i) begin
      fwda_o       = fwda_c;
      fwdb_o       = fwdb_c;
      stall_o      = stall_c;
      mdu_busy_o   = pend_q;
      mdu_done_o   = mdu_done_c;
      mdu_des_o    = mdu_des_q;
      smc_flush_o  = smc_hit;
      smc_flush2_o = flush2_c;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  localparam int RB = 5;
  localparam int FS = 2;
  localparam int MDU_LAT = 4;
  localparam int SMC_DRAIN = 2;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic resetn;
  logic id_valid, id_use_rs, id_use_rt, id_wreg, id_is_mdu, ex_wmem;
  logic [RB-1:0] id_rs, id_rt, id_des;
  logic [FS-1:0] st_wreg, st_m2reg;
  logic [FS*RB-1:0] st_des;
  logic [AW-1:0] ex_addr, id_pc, if_pc;
  logic [1:0] fwda, fwdb;
  logic stall, mdu_busy, mdu_done, smc_flush, smc_flush2;
  logic [RB-1:0] mdu_des;

  pipe_hazard_ctrl #(.RB(RB), .FWD_STAGES(FS), .MDU_LAT(MDU_LAT), .SMC_DRAIN(SMC_DRAIN), .AW(AW)) dut (
    .clk_i(clk), .resetn_i(resetn), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt), .id_wreg_i(id_wreg), .id_des_i(id_des),
    .id_is_mdu_i(id_is_mdu), .st_wreg_i(st_wreg), .st_m2reg_i(st_m2reg), .st_des_i(st_des),
    .ex_wmem_i(ex_wmem), .ex_addr_i(ex_addr), .id_pc_i(id_pc), .if_pc_i(if_pc),
    .fwda_o(fwda), .fwdb_o(fwdb), .stall_o(stall), .mdu_busy_o(mdu_busy), .mdu_done_o(mdu_done),
    .mdu_des_o(mdu_des), .smc_flush_o(smc_flush), .smc_flush2_o(smc_flush2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] fa;
    logic [1:0] fb;
    logic       stall;
    logic       busy;
    logic       done;
    logic [4:0] des;
    logic       fl;
    logic       fl2;
  } exp_t;

  typedef struct {
    string nm;
    int    sel;
    int    val;
  } lit_t;

  lit_t lq[$];
  int n_pass = 0;
  int n_tot = 0;

  // Model state: cycles left until the MDU result (0 = idle), and drain cycles left
  int m_left = 0;
  int m_drain = 0;
  logic [4:0] m_des = '0;

  function automatic bit mt(logic u, logic [4:0] i, logic [4:0] d);
    return u && (i != 0) && (i == d);
  endfunction

  function automatic logic [4:0] sd(int k);
    return st_des[k*RB +: RB];
  endfunction

  function automatic exp_t model();
    exp_t e;
    int fa, fb;
    bit lu, ms, hit;
    e = '0;
    if (resetn !== 1'b1) return e;
    fa = 0;
    fb = 0;
    for (int k = FS - 1; k >= 0; k--) begin
      if (st_wreg[k] && mt(id_use_rs, id_rs, sd(k))) fa = k + 1;
      if (st_wreg[k] && mt(id_use_rt, id_rt, sd(k))) fb = k + 1;
    end
    lu = st_m2reg[0] && st_wreg[0] && (mt(id_use_rs, id_rs, sd(0)) || mt(id_use_rt, id_rt, sd(0)));
    ms = (m_left > 0) && (mt(id_use_rs, id_rs, m_des) || mt(id_use_rt, id_rt, m_des) ||
         (id_wreg && id_des != 0 && id_des == m_des) || id_is_mdu);
    hit = (m_drain == 0) && ex_wmem && (ex_addr == id_pc);
    e.fa = 2'(fa);
    e.fb = 2'(fb);
    e.stall = lu || ms || hit || (m_drain > 0);
    e.busy = (m_left > 0);
    e.done = (m_left == 1);
    e.des = m_des;
    e.fl = hit;
    e.fl2 = ex_wmem && (ex_addr == if_pc);
    return e;
  endfunction

  // Model state advance at each rising edge
  always @(posedge clk) begin
    exp_t e;
    e = model();
    if (resetn !== 1'b1) begin
      m_left <= 0;
      m_des <= '0;
      m_drain <= 0;
    end else begin
      if (m_left > 0) m_left <= m_left - 1;
      if (id_valid && id_is_mdu && !e.stall) begin
        m_left <= MDU_LAT;
        m_des <= id_des;
      end
      if (m_drain > 0) m_drain <= m_drain - 1;
      else if (e.fl) m_drain <= SMC_DRAIN;
    end
  end

  function automatic int outv(int sel);
    case (sel)
      0: return int'(fwda);
      1: return int'(fwdb);
      2: return int'(stall);
      3: return int'(mdu_busy);
      4: return int'(mdu_done);
      5: return int'(mdu_des);
      6: return int'(smc_flush);
      default: return int'(smc_flush2);
    endcase
  endfunction

  task automatic cmp(string nm, int act, int req);
    n_tot++;
    if (act == req) n_pass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, req);
  endtask

  // Single compare process: model check every cycle, then any queued literal checks
  always @(negedge clk) begin
    exp_t e;
    lit_t l;
    e = model();
    cmp("fwda", int'(fwda), int'(e.fa));
    cmp("fwdb", int'(fwdb), int'(e.fb));
    cmp("stall", int'(stall), int'(e.stall));
    cmp("mdu_busy", int'(mdu_busy), int'(e.busy));
    cmp("mdu_done", int'(mdu_done), int'(e.done));
    cmp("mdu_des", int'(mdu_des), int'(e.des));
    cmp("smc_flush", int'(smc_flush), int'(e.fl));
    cmp("smc_flush2", int'(smc_flush2), int'(e.fl2));
    while (lq.size() > 0) begin
      l = lq.pop_front();
      cmp(l.nm, outv(l.sel), l.val);
    end
  end

  task automatic lit(string nm, int sel, int val);
    lit_t l;
    l.nm = nm;
    l.sel = sel;
    l.val = val;
    lq.push_back(l);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic neutral();
    id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    id_wreg = 0; id_des = 0; id_is_mdu = 0;
    st_wreg = 0; st_m2reg = 0; st_des = 0;
    ex_wmem = 0; ex_addr = 0; id_pc = 32'h1000; if_pc = 32'h1004;
  endtask

  task automatic mdu_issue(logic [4:0] d);
    neutral();
    id_valid = 1; id_is_mdu = 1; id_wreg = 1; id_des = d;
  endtask

  initial begin
    resetn = 0;
    neutral();
    lit("rst_stall", 2, 0); lit("rst_busy", 3, 0); lit("rst_des", 5, 0);
    cyc(); cyc();
    resetn = 1;

    // Forwarding priority and $0
    neutral(); id_valid = 1; id_rs = 5; id_use_rs = 1; st_wreg = 2'b11; st_des = {5'd5, 5'd5};
    lit("t1_fwda_ex", 0, 1);
    cyc();
    st_wreg = 2'b10; id_rt = 5; id_use_rt = 1;
    lit("t1_fwda_mem", 0, 2); lit("t1_fwdb_mem", 1, 2);
    cyc();
    neutral(); id_rs = 0; id_use_rs = 1; st_wreg = 2'b11; st_des = '0;
    lit("t1_fwda_r0", 0, 0);
    cyc();

    // Load-use
    neutral(); id_valid = 1; id_rt = 7; id_use_rt = 1; st_wreg = 2'b01; st_m2reg = 2'b01; st_des = {5'd0, 5'd7};
    lit("t2_lu_stall", 2, 1);
    cyc();
    st_wreg = 2'b10; st_m2reg = 2'b10; st_des = {5'd7, 5'd0};
    lit("t2_mem_stall", 2, 0); lit("t2_mem_fwdb", 1, 2);
    cyc();

    // MDU issue and RAW wait
    mdu_issue(5'd9);
    lit("t3_c0_stall", 2, 0); lit("t3_c0_busy", 3, 0);
    cyc();
    for (int c = 1; c <= 5; c++) begin
      neutral(); id_valid = 1; id_rs = 9; id_use_rs = 1; id_wreg = 1; id_des = 3;
      lit("t3_busy", 3, (c <= 4) ? 1 : 0);
      lit("t3_stall", 2, (c <= 4) ? 1 : 0);
      lit("t3_done", 4, (c == 4) ? 1 : 0);
      if (c == 1) lit("t3_des", 5, 9);
      cyc();
    end

    // Single MDU in flight, then WAW
    mdu_issue(5'd9);
    cyc();
    neutral(); id_valid = 1; id_wreg = 1; id_des = 3;
    lit("t4_c1_stall", 2, 0);
    cyc();
    for (int c = 2; c <= 5; c++) begin
      mdu_issue(5'd10);
      lit("t4_mdu_stall", 2, (c <= 4) ? 1 : 0);
      cyc();
    end
    neutral(); id_valid = 1; id_wreg = 1; id_des = 10;
    lit("t4_busy2", 3, 1); lit("t4_des2", 5, 10); lit("t4_waw", 2, 1);
    cyc();
    neutral(); id_valid = 1; id_wreg = 1; id_des = 11;
    lit("t4_nowaw", 2, 0);
    cyc();
    neutral();
    repeat (4) cyc();

    // SMC flush and drain
    neutral(); ex_wmem = 1; ex_addr = 32'h40; id_pc = 32'h40; if_pc = 32'h44;
    lit("t5_flush", 6, 1); lit("t5_stall0", 2, 1); lit("t5_flush2_0", 7, 0);
    cyc();
    lit("t5_rehit_ignored", 6, 0); lit("t5_stall1", 2, 1);
    cyc();
    ex_wmem = 0;
    lit("t5_stall2", 2, 1);
    cyc();
    lit("t5_stall3", 2, 0);
    cyc();
    ex_wmem = 1; ex_addr = 32'h80; id_pc = 32'h40; if_pc = 32'h80;
    lit("t5_f2_only", 7, 1); lit("t5_f2_noflush", 6, 0); lit("t5_f2_nostall", 2, 0);
    cyc();
    ex_addr = 32'h100; id_pc = 32'h100; if_pc = 32'h100;
    lit("t5_both_f", 6, 1); lit("t5_both_f2", 7, 1);
    cyc();
    neutral();
    repeat (3) cyc();

    // Reset during MDU
    mdu_issue(5'd9);
    cyc();
    neutral();
    cyc();
    resetn = 0;
    id_valid = 1; id_rs = 9; id_use_rs = 1; id_rt = 9; id_use_rt = 1;
    st_wreg = 2'b11; st_m2reg = 2'b01; st_des = {5'd9, 5'd9};
    ex_wmem = 1; ex_addr = 32'h40; id_pc = 32'h40; if_pc = 32'h40;
    for (int s = 0; s < 8; s++) lit("t6_rst_out", s, 0);
    cyc();
    resetn = 1;
    neutral(); id_valid = 1; id_rs = 9; id_use_rs = 1;
    lit("t6_busy", 3, 0); lit("t6_stall", 2, 0);
    cyc();
    for (int c = 0; c < 4; c++) begin
      lit("t6_nodone", 4, 0);
      cyc();
    end

    // Mixed pseudo-random traffic against the model
    for (int i = 0; i < 400; i++) begin
      resetn = ($urandom_range(0, 49) != 0);
      id_valid = 1'($urandom_range(0, 1));
      id_rs = 5'($urandom_range(0, 6));
      id_rt = 5'($urandom_range(0, 6));
      id_use_rs = 1'($urandom_range(0, 1));
      id_use_rt = 1'($urandom_range(0, 1));
      id_wreg = 1'($urandom_range(0, 1));
      id_des = 5'($urandom_range(0, 6));
      id_is_mdu = ($urandom_range(0, 5) == 0);
      st_wreg = 2'($urandom_range(0, 3));
      st_m2reg = 2'($urandom_range(0, 3));
      st_des = {5'($urandom_range(0, 6)), 5'($urandom_range(0, 6))};
      ex_wmem = ($urandom_range(0, 7) == 0);
      ex_addr = 32'h40 + 32'($urandom_range(0, 2)) * 4;
      id_pc = 32'h40 + 32'($urandom_range(0, 2)) * 4;
      if_pc = 32'h40 + 32'($urandom_range(0, 2)) * 4;
      cyc();
    end
    resetn = 1;
    neutral();
    cyc();

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
